// File: rtl/z16_pkg.sv
// Shared Z16 definitions: fetch state encoding, datapath widths and fetch constants.
package z16_pkg;

    localparam int Z16_INSTR_W = 16;
    localparam int Z16_ADDR_W  = 16;

    localparam logic [Z16_ADDR_W-1:0]  Z16_PC_STEP   = 16'd2;
    localparam logic [Z16_INSTR_W-1:0] Z16_HALT_WORD = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } z16_state_e;

    // Instructions are halfword aligned, so bit 0 of any target is dropped.
    function automatic logic [Z16_ADDR_W-1:0] z16_align(input logic [Z16_ADDR_W-1:0] addr);
        return {addr[Z16_ADDR_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/z16_if_id_reg.sv
// IF/ID pipeline register: valid bit plus the fetched instruction and its PC.
module z16_if_id_reg
    import z16_pkg::*;
(
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_capture,
    input  logic                   i_flush,
    input  logic [Z16_INSTR_W-1:0] i_instr,
    input  logic [Z16_ADDR_W-1:0]  i_pc,
    output logic                   o_valid,
    output logic [Z16_INSTR_W-1:0] o_instr,
    output logic [Z16_ADDR_W-1:0]  o_pc
);

    // Flush clears only the valid bit; capture loads a new word and sets valid;
    // with neither asserted everything holds, which is how a stall is presented.
    logic                   valid_d, valid_q;
    logic [Z16_INSTR_W-1:0] instr_d, instr_q;
    logic [Z16_ADDR_W-1:0]  pc_d,    pc_q;

    always_comb begin
        valid_d = valid_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (i_flush) begin
            valid_d = 1'b0;
        end else if (i_capture) begin
            valid_d = 1'b1;
            instr_d = i_instr;
            pc_d    = i_pc;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            instr_q <= '0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

    assign o_valid = valid_q;
    assign o_instr = instr_q;
    assign o_pc    = pc_q;

endmodule

// File: rtl/z16_fetch_unit.sv
// Z16 fetch stage: owns the PC and fetch FSM, feeds the IF/ID register.
// Optional halt-on-zero-word behaviour is enabled by defining Z16_FETCH_HALT_EN.
module z16_fetch_unit
    import z16_pkg::*;
#(
    parameter logic [Z16_ADDR_W-1:0] RESET_PC = 16'h0000
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    output logic [Z16_ADDR_W-1:0]  o_imem_addr,
    input  logic [Z16_INSTR_W-1:0] i_imem_instr,
    input  logic                   i_stall,
    input  logic                   i_redirect,
    input  logic [Z16_ADDR_W-1:0]  i_redirect_addr,
    output logic                   o_valid,
    output logic [Z16_INSTR_W-1:0] o_instr,
    output logic [Z16_ADDR_W-1:0]  o_pc,
    output logic                   o_halted,
    output logic [1:0]             o_dbg_state
);

    z16_state_e            state_d, state_q;
    logic [Z16_ADDR_W-1:0] pc_d, pc_q;
    logic                  capture;
    logic                  flush;
`ifdef Z16_FETCH_HALT_EN
    logic                  halted_d, halted_q;
`endif

    // Priority per edge: redirect, then stall, then the per-state action.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        capture = 1'b0;
        flush   = 1'b0;
`ifdef Z16_FETCH_HALT_EN
        halted_d = halted_q;
`endif
        if (i_redirect) begin
            pc_d    = z16_align(i_redirect_addr);
            state_d = ST_RUN;
            flush   = 1'b1;
`ifdef Z16_FETCH_HALT_EN
            halted_d = 1'b0;
`endif
        end else if (!i_stall) begin
            case (state_q)
                ST_IDLE: state_d = ST_RUN;
                ST_RUN: begin
`ifdef Z16_FETCH_HALT_EN
                    if (i_imem_instr == Z16_HALT_WORD) begin
                        // PC stays on the zero word so a debugger sees where fetch stopped.
                        state_d  = ST_HALT;
                        flush    = 1'b1;
                        halted_d = 1'b1;
                    end else begin
                        capture = 1'b1;
                        pc_d    = pc_q + Z16_PC_STEP;
                    end
`else
                    capture = 1'b1;
                    pc_d    = pc_q + Z16_PC_STEP;
`endif
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef Z16_FETCH_HALT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end
    assign o_halted = halted_q;
`else
    assign o_halted = 1'b0;
`endif

    z16_if_id_reg u_if_id (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_capture (capture),
        .i_flush   (flush),
        .i_instr   (i_imem_instr),
        .i_pc      (pc_q),
        .o_valid   (o_valid),
        .o_instr   (o_instr),
        .o_pc      (o_pc)
    );

    assign o_imem_addr = pc_q;
    assign o_dbg_state = state_q;

endmodule
